// File: rtl/seq_detector_pkg.sv
// seq_pkg: lock FSM state encodings and pattern/period defaults shared with the generator
package seq_pkg;
  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } lock_state_t;
  localparam logic [7:0] DEF_PATTERN = 8'b0111_0100;
  localparam int DEF_PERIOD = 16;
endpackage

// File: rtl/seq_detector_if.sv
// seq_detector_if: serial bit input and detector result bundle
interface seq_detector_if #(parameter int CNT_W = 8);
  logic bit_en;
  logic din;
  logic match;
  logic [CNT_W-1:0] match_cnt;
  logic locked;
  logic [5:0] led_6bit;
  modport master(output bit_en, din, input match, match_cnt, locked, led_6bit);
  modport slave(input bit_en, din, output match, match_cnt, locked, led_6bit);
endinterface

// File: rtl/seq_detector_lock_fsm.sv
// seq_lock_fsm: periodic frame lock tracker driven by per-bit match strobes
module seq_lock_fsm
  import seq_pkg::*;
#(
  parameter int PERIOD   = DEF_PERIOD,
  parameter int LOCK_CNT = 2,
  parameter int MISS_CNT = 2
) (
  input  logic sysclk,
  input  logic rst,
  input  logic bit_en,
  input  logic match_comb,
  output logic locked
);
  localparam int PH_W = $clog2(PERIOD);
  localparam int CF_W = $clog2(LOCK_CNT + 1);
  localparam int MS_W = $clog2(MISS_CNT + 1);
  localparam logic [PH_W-1:0] SLOT = PH_W'(PERIOD - 1);
  lock_state_t state, state_n;
  logic [PH_W-1:0] phase, phase_n;
  logic [CF_W-1:0] conf, conf_n;
  logic [MS_W-1:0] miss, miss_n;
  logic slot;
  assign slot = bit_en && phase == SLOT;
  assign locked = state == ST_LOCKED;
  // state, phase and confidence/miss registers
  always_ff @(posedge sysclk)
    if (rst) begin
      state <= ST_HUNT;
      phase <= '0;
      conf  <= '0;
      miss  <= '0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      conf  <= conf_n;
      miss  <= miss_n;
    end
  // phase re-anchors on tracked matches, otherwise free-runs modulo PERIOD
  always_comb begin
    state_n = state;
    phase_n = phase;
    conf_n  = conf;
    miss_n  = miss;
    if (bit_en)
      phase_n = (slot || (match_comb && state != ST_LOCKED)) ? '0 : phase + 1'b1;
    case (state)
      ST_HUNT: if (match_comb) begin
        state_n = ST_VERIFY;
        conf_n  = '0;
      end
      ST_VERIFY:
        if (slot && match_comb) begin
          conf_n = conf + 1'b1;
          if (conf_n == CF_W'(LOCK_CNT)) begin
            state_n = ST_LOCKED;
            miss_n  = '0;
          end
        end else if (slot) state_n = ST_HUNT;
        else if (match_comb) conf_n = '0;
      ST_LOCKED:
        if (slot && match_comb) miss_n = '0;
        else if (slot) begin
          miss_n = miss + 1'b1;
          if (miss_n == MS_W'(MISS_CNT)) state_n = ST_HUNT;
        end
      default: state_n = ST_HUNT;
    endcase
  end
endmodule

// File: rtl/seq_detector.sv
// seq_detector: serial pattern detector with match counter, LED mirror and optional frame lock (SEQ_DET_LOCK_EN)
module seq_detector
  import seq_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
  parameter int PERIOD   = DEF_PERIOD,
  parameter int LOCK_CNT = 2,
  parameter int MISS_CNT = 2,
  parameter int CNT_W    = 8
) (
  input logic sysclk,
  input logic rst,
  seq_detector_if.slave bus
);
  localparam int FILL_W = $clog2(PAT_W + 1);
  logic [PAT_W-1:0] sr, sr_n;
  logic [FILL_W-1:0] fill, fill_n;
  logic match_comb;
  // a partially filled window never matches, even if its zeros happen to fit
  always_comb begin
    sr_n = {sr[PAT_W-2:0], bus.din};
    fill_n = (fill == FILL_W'(PAT_W)) ? fill : fill + 1'b1;
    match_comb = bus.bit_en && sr_n == PATTERN && fill_n == FILL_W'(PAT_W);
  end
  // window, fill, LED mirror and saturating match counter
  always_ff @(posedge sysclk)
    if (rst) begin
      sr            <= '0;
      fill          <= '0;
      bus.match     <= 1'b0;
      bus.match_cnt <= '0;
      bus.led_6bit  <= '0;
    end else begin
      bus.match <= match_comb;
      if (bus.bit_en) begin
        sr           <= sr_n;
        fill         <= fill_n;
        bus.led_6bit <= {bus.led_6bit[4:0], bus.din};
      end
      if (match_comb && bus.match_cnt != '1) bus.match_cnt <= bus.match_cnt + 1'b1;
    end
`ifdef SEQ_DET_LOCK_EN
  seq_lock_fsm #(
    .PERIOD  (PERIOD),
    .LOCK_CNT(LOCK_CNT),
    .MISS_CNT(MISS_CNT)
  ) u_lock (
    .sysclk    (sysclk),
    .rst       (rst),
    .bit_en    (bus.bit_en),
    .match_comb(match_comb),
    .locked    (bus.locked)
  );
`else
  assign bus.locked = 1'b0;
`endif
endmodule

// File: tb/tb_seq_detector.sv
// tb_seq_detector: directed checks of seq_detector (lock expectations follow SEQ_DET_LOCK_EN)
module tb_seq_detector;
  import seq_pkg::*;
  logic sysclk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;
  logic [7:0] pat = 8'b0111_0100;
  seq_detector_if #(.CNT_W(8)) bus ();
  seq_detector_if #(.CNT_W(2)) bus2 ();
  always #5 sysclk = ~sysclk;
  seq_detector #(.CNT_W(8)) dut (.sysclk(sysclk), .rst(rst), .bus(bus));
  seq_detector #(.CNT_W(2)) dut2 (.sysclk(sysclk), .rst(rst), .bus(bus2));

  task automatic idle(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic strobe(input logic b);
    bus.bit_en = 1'b1;
    bus.din = b;
    @(negedge sysclk);
    bus.bit_en = 1'b0;
    bus.din = 1'b0;
  endtask

  task automatic strobe2(input logic b);
    bus2.bit_en = 1'b1;
    bus2.din = b;
    @(negedge sysclk);
    bus2.bit_en = 1'b0;
    bus2.din = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(3);
    compared += 4;
    if (bus.match !== 1'b0) begin mismatched++; $display("FAIL reset_match got %b want 0", bus.match); end
    if (bus.match_cnt !== 8'd0) begin mismatched++; $display("FAIL reset_cnt got %0d want 0", bus.match_cnt); end
    if (bus.led_6bit !== 6'd0) begin mismatched++; $display("FAIL reset_led got %b want 000000", bus.led_6bit); end
    if (bus.locked !== 1'b0) begin mismatched++; $display("FAIL reset_locked got %b want 0", bus.locked); end
    rst = 1'b0;
  endtask

  task automatic test_single;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      strobe(pat[7-i]);
      compared++;
      if (bus.match !== (i == 7)) begin mismatched++; $display("FAIL single_match bit %0d got %b want %b", i + 1, bus.match, i == 7); end
      idle(3);
    end
    compared += 3;
    if (bus.match !== 1'b0) begin mismatched++; $display("FAIL single_pulse_width got %b want 0", bus.match); end
    if (bus.match_cnt !== 8'd1) begin mismatched++; $display("FAIL single_cnt got %0d want 1", bus.match_cnt); end
    if (bus.led_6bit !== 6'b110100) begin mismatched++; $display("FAIL single_led got %b want 110100", bus.led_6bit); end
    idle(10);
    compared += 2;
    if (bus.match_cnt !== 8'd1) begin mismatched++; $display("FAIL hold_cnt got %0d want 1", bus.match_cnt); end
    if (bus.led_6bit !== 6'b110100) begin mismatched++; $display("FAIL hold_led got %b want 110100", bus.led_6bit); end
  endtask

  task automatic test_partial;
    logic [6:0] q = 7'b1110100;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      strobe(q[6-i]);
      compared++;
      if (bus.match !== 1'b0) begin mismatched++; $display("FAIL partial_match bit %0d got %b want 0", i + 1, bus.match); end
    end
    idle(2);
    compared += 2;
    if (bus.match_cnt !== 8'd0) begin mismatched++; $display("FAIL partial_cnt got %0d want 0", bus.match_cnt); end
    if (bus.led_6bit !== 6'b110100) begin mismatched++; $display("FAIL partial_led got %b want 110100", bus.led_6bit); end
  endtask

  task automatic test_back_to_back;
    logic [14:0] s = 15'b011101001110100;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      strobe(s[14-i]);
      compared++;
      if (bus.match !== (i == 7 || i == 14)) begin mismatched++; $display("FAIL b2b_match bit %0d got %b want %b", i + 1, bus.match, i == 7 || i == 14); end
    end
    compared++;
    if (bus.match_cnt !== 8'd2) begin mismatched++; $display("FAIL b2b_cnt got %0d want 2", bus.match_cnt); end
  endtask

  task automatic test_saturate;
    logic [1:0] exp;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      exp = (k < 3) ? 2'(k + 1) : 2'd3;
      for (int i = 0; i < 8; i++) begin
        strobe2(pat[7-i]);
        if (i == 7) begin
          compared += 2;
          if (bus2.match !== 1'b1) begin mismatched++; $display("FAIL sat_match rep %0d got %b want 1", k + 1, bus2.match); end
          if (bus2.match_cnt !== exp) begin mismatched++; $display("FAIL sat_cnt rep %0d got %0d want %0d", k + 1, bus2.match_cnt, exp); end
        end
      end
    end
  endtask

  task automatic test_lock;
    logic [15:0] w = 16'b0111010011011010;
    logic b, flip, exp_m, exp_l;
    int n;
    do_reset();
    for (int p = 0; p < 10; p++) begin
      flip = (p == 4 || p == 5);
      for (int i = 0; i < 16; i++) begin
        n = p * 16 + i + 1;
        b = w[15-i] ^ (flip && i == 2);
        strobe(b);
        exp_m = !flip && i == 7;
`ifdef SEQ_DET_LOCK_EN
        exp_l = (n >= 40 && n < 88) || n >= 136;
`else
        exp_l = 1'b0;
`endif
        compared += 2;
        if (bus.match !== exp_m) begin mismatched++; $display("FAIL lock_match bit %0d got %b want %b", n, bus.match, exp_m); end
        if (bus.locked !== exp_l) begin mismatched++; $display("FAIL lock_locked bit %0d got %b want %b", n, bus.locked, exp_l); end
      end
    end
    compared++;
    if (bus.match_cnt !== 8'd8) begin mismatched++; $display("FAIL lock_cnt got %0d want 8", bus.match_cnt); end
  endtask

  task automatic test_reset_collision;
    do_reset();
    for (int i = 0; i < 8; i++) strobe(pat[7-i]);
    for (int i = 0; i < 7; i++) strobe(pat[7-i]);
    compared++;
    if (bus.match_cnt !== 8'd1) begin mismatched++; $display("FAIL coll_pre_cnt got %0d want 1", bus.match_cnt); end
    bus.bit_en = 1'b1;
    bus.din = pat[0];
    rst = 1'b1;
    @(negedge sysclk);
    bus.bit_en = 1'b0;
    bus.din = 1'b0;
    rst = 1'b0;
    compared += 4;
    if (bus.match !== 1'b0) begin mismatched++; $display("FAIL coll_match got %b want 0", bus.match); end
    if (bus.match_cnt !== 8'd0) begin mismatched++; $display("FAIL coll_cnt got %0d want 0", bus.match_cnt); end
    if (bus.led_6bit !== 6'd0) begin mismatched++; $display("FAIL coll_led got %b want 000000", bus.led_6bit); end
    if (bus.locked !== 1'b0) begin mismatched++; $display("FAIL coll_locked got %b want 0", bus.locked); end
    idle(1);
    compared++;
    if (bus.match !== 1'b0) begin mismatched++; $display("FAIL coll_match_late got %b want 0", bus.match); end
  endtask

  initial begin
    bus.bit_en = 1'b0;
    bus.din = 1'b0;
    bus2.bit_en = 1'b0;
    bus2.din = 1'b0;
    test_reset();
    test_single();
    test_partial();
    test_back_to_back();
    test_saturate();
    test_lock();
    test_reset_collision();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
